// File: rtl/inst_mem_pkg.sv
// Shared definitions for the instruction memory and its program loader.
package inst_mem_pkg;

  localparam int D_WIDTH_DEF  = 32;
  localparam int SA_WIDTH_DEF = 4;
  localparam int BYTE_W       = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_COMMIT = 2'd2,
    S_DROP   = 2'd3
  } ld_state_t;

endpackage

// File: rtl/inst_mem_mem_array.sv
// Word-wide storage array: one synchronous write port shared by loader and
// processor (loader wins), one synchronous read port. No reset on contents.
module mem_array #(
  parameter int D_WIDTH  = 32,
  parameter int SA_WIDTH = 4
) (
  input  logic                clk,
  input  logic                ld_we,
  input  logic [SA_WIDTH-1:0] ld_addr,
  input  logic [D_WIDTH-1:0]  ld_data,
  input  logic                pr_we,
  input  logic [SA_WIDTH-1:0] pr_addr,
  input  logic [D_WIDTH-1:0]  pr_data,
  input  logic                re,
  input  logic [SA_WIDTH-1:0] raddr,
  output logic [D_WIDTH-1:0]  rdata
);

  localparam int DEPTH = 1 << SA_WIDTH;

  logic [D_WIDTH-1:0] mem [DEPTH];

  // Single write port: a loader commit takes precedence over a processor write.
  always_ff @(posedge clk) begin
    if (ld_we) begin
      mem[ld_addr] <= ld_data;
    end else if (pr_we) begin
      mem[pr_addr] <= pr_data;
    end
  end

  // Registered read; the output holds between reads.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/inst_mem.sv
// Instruction memory with a byte-stream program loader. The loader packs
// bytes MSB-first into words and commits them from address 0 upward; while a
// load is running, processor accesses are ignored.
module inst_mem
  import inst_mem_pkg::*;
#(
  parameter int D_WIDTH  = D_WIDTH_DEF,
  parameter int SA_WIDTH = SA_WIDTH_DEF
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic [SA_WIDTH-1:0] Addr,
  input  logic                En,
  input  logic                RW,
  input  logic [D_WIDTH-1:0]  WData,
  output logic [D_WIDTH-1:0]  Data,
  output logic                Ack,
  input  logic [7:0]          LdByte,
  input  logic                LdValid,
  input  logic                LdLast,
  output logic                LdReady,
  output logic                Busy,
  output logic                LdErr,
  output logic [SA_WIDTH:0]   LdCount
);

  localparam int BYTES = D_WIDTH / BYTE_W;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [SA_WIDTH:0] FULL    = (SA_WIDTH + 1)'(1 << SA_WIDTH);
  localparam logic [SA_WIDTH:0] CNT_ONE = (SA_WIDTH + 1)'(1);
  localparam logic [IDX_W-1:0]  IDX_ONE = IDX_W'(1);
  localparam logic [IDX_W-1:0]  IDX_END = IDX_W'(BYTES - 1);

  ld_state_t state, state_next;

  logic [D_WIDTH-1:0] packer;
  logic [D_WIDTH-1:0] packed_next;
  logic [IDX_W-1:0]   byte_idx;
  logic               last_seen;
  logic [SA_WIDTH:0]  count;
  logic               err;
  logic               ready_en;
  logic               ack;
  logic               rd_seen;
  logic [D_WIDTH-1:0] rdata;
  logic               byte_take;
  logic               word_done;
  logic               proc_go;
  logic               commit;
  int                 shamt;

  assign Busy      = (state != S_IDLE);
  assign LdReady   = ready_en && (state != S_COMMIT);
  assign byte_take = LdValid && LdReady;
  assign word_done = (byte_idx == IDX_END) || LdLast;
  assign proc_go   = En && !Busy;
  assign commit    = (state == S_COMMIT);
  assign LdCount   = count;
  assign LdErr     = err;
  assign Ack       = ack;
  assign Data      = rd_seen ? rdata : '0;

  // Drop the incoming byte into its MSB-first slot; a new image starts from zero.
  always_comb begin
    shamt       = BYTE_W * (BYTES - 1 - int'(byte_idx));
    packed_next = ((state == S_IDLE) ? '0 : packer) | (D_WIDTH'(LdByte) << shamt);
  end

  // Loader state register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Loader next-state: pack bytes, commit each word, discard anything past a full memory.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (byte_take) begin
          state_next = word_done ? S_COMMIT : S_LOAD;
        end
      end
      S_LOAD: begin
        if (byte_take && word_done) begin
          state_next = S_COMMIT;
        end
      end
      S_COMMIT: begin
        if (last_seen) begin
          state_next = S_IDLE;
        end else if ((count + CNT_ONE) < FULL) begin
          state_next = S_LOAD;
        end else begin
          state_next = S_DROP;
        end
      end
      S_DROP: begin
        if (byte_take && LdLast) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Loader datapath: packer, byte slot, word count and overflow flag.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      packer    <= '0;
      byte_idx  <= '0;
      last_seen <= 1'b0;
      count     <= '0;
      err       <= 1'b0;
      ready_en  <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      case (state)
        S_IDLE: begin
          if (byte_take) begin
            packer    <= packed_next;
            byte_idx  <= byte_idx + IDX_ONE;
            last_seen <= LdLast;
            count     <= '0;
            err       <= 1'b0;
          end
        end
        S_LOAD: begin
          if (byte_take) begin
            packer    <= packed_next;
            byte_idx  <= byte_idx + IDX_ONE;
            last_seen <= LdLast;
          end
        end
        S_COMMIT: begin
          packer   <= '0;
          byte_idx <= '0;
          if (count != FULL) begin
            count <= count + CNT_ONE;
          end
        end
        S_DROP: begin
          if (byte_take) begin
            err <= 1'b1;
          end
        end
        default: begin
          packer <= '0;
        end
      endcase
    end
  end

  // Processor side: acknowledge each accepted access and remember that Data is valid.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      ack     <= 1'b0;
      rd_seen <= 1'b0;
    end else begin
      ack <= proc_go;
      if (proc_go && !RW) begin
        rd_seen <= 1'b1;
      end
    end
  end

  mem_array #(
    .D_WIDTH (D_WIDTH),
    .SA_WIDTH(SA_WIDTH)
  ) u_mem (
    .clk    (Clk),
    .ld_we  (commit),
    .ld_addr(count[SA_WIDTH-1:0]),
    .ld_data(packer),
    .pr_we  (proc_go && RW),
    .pr_addr(Addr),
    .pr_data(WData),
    .re     (proc_go && !RW),
    .raddr  (Addr),
    .rdata  (rdata)
  );

endmodule

// File: doc/inst_mem.md
INST_MEM -- requirements
Module: inst_mem

Interface
REQ-001 SHALL have parameter D_WIDTH, default `D_WIDTH (32), data word width.
REQ-002 SHALL have parameter SA_WIDTH, default `SA_WIDTH (4), word address width; depth = 2^SA_WIDTH (16 words).
REQ-003 SHALL have port Clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port Rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port Addr  input  SA_WIDTH  processor word address.
REQ-006 SHALL have port En  input  1  processor access strobe.
REQ-007 SHALL have port RW  input  1  0 = read, 1 = write.
REQ-008 SHALL have port WData  input  D_WIDTH  processor write data.
REQ-009 SHALL have port Data  output  D_WIDTH  registered read data.
REQ-010 SHALL have port Ack  output  1  one-cycle access-complete pulse.
REQ-011 SHALL have port LdByte  input  8  program-load byte, MSB-first within word.
REQ-012 SHALL have port LdValid  input  1  LdByte valid.
REQ-013 SHALL have port LdLast  input  1  qualifies final byte of image.
REQ-014 SHALL have port LdReady  output  1  loader accepts byte when LdValid&LdReady.
REQ-015 SHALL have port Busy  output  1  load in progress, processor accesses blocked.
REQ-016 SHALL have port LdErr  output  1  sticky image-overflow flag.
REQ-017 SHALL have port LdCount  output  SA_WIDTH+1  words committed by current/last load.

Function
REQ-018 Processor read: En=1, RW=0, Busy=0 at edge n -> Data=mem[Addr], Ack=1 after edge n+1; latency 1.
REQ-019 Processor write: En=1, RW=1, Busy=0 at edge n -> mem[Addr]=WData at edge n, Ack=1 after edge n+1; Data unchanged.
REQ-020 Ack SHALL be high exactly one cycle per accepted access; back-to-back En gives Ack every cycle.
REQ-021 Data SHALL hold its last value when no read completes.
REQ-022 Accesses with Busy=1 SHALL be ignored: no Ack, no write, Data unchanged.
REQ-023 FSM states: S_IDLE, S_LOAD, S_COMMIT, S_DROP.
REQ-024 S_IDLE: LdValid&LdReady -> byte captured, LdPtr=0, LdCount=0, LdErr=0, -> S_LOAD; a processor access in that same cycle is still serviced.
REQ-025 S_LOAD: bytes shift into 32-bit packer MSB-first; 4th byte or LdLast -> S_COMMIT.
REQ-026 LdLast on byte k<4 SHALL zero-pad the remaining low bytes.
REQ-027 S_COMMIT (1 cycle, LdReady=0): mem[LdPtr]=packed word, LdPtr+1, LdCount+1; -> S_IDLE if LdLast was seen, else S_LOAD if LdCount<16, else S_DROP.
REQ-028 S_DROP: bytes accepted and discarded, LdErr=1 on first dropped byte; LdLast -> S_IDLE.
REQ-029 LdPtr wraps never; LdCount saturates at 16.
REQ-030 Busy=1 in S_LOAD, S_COMMIT, S_DROP; Busy asserts the cycle after the first byte is accepted.
REQ-031 LdReady=1 in S_IDLE, S_LOAD, S_DROP; 0 in S_COMMIT and during reset.

Reset
REQ-032 Rst low SHALL asynchronously force S_IDLE, Data=0, Ack=0, Busy=0, LdErr=0, LdCount=0, LdReady=0, packer=0.
REQ-033 Memory array SHALL NOT be reset; contents undefined until written.
REQ-034 Rst asserted mid-load SHALL abandon the partial word; no commit occurs.
REQ-035 LdReady SHALL rise on the first edge after Rst deasserts.

Structure
REQ-036 D_WIDTH and SA_WIDTH SHALL come from define.h; FSM encodings are local parameters.
REQ-037 Storage SHALL be sub-module mem_array (2^SA_WIDTH x D_WIDTH, 1 sync read, 1 sync write, loader write priority, no reset).

Verification
REQ-038 Load 8 bytes 01..08, LdLast on 08 -> mem[0]=0x01020304, mem[1]=0x05060708, LdCount=2, Busy low after commit.
REQ-039 Read Addr=1 after REQ-038 load -> Ack one cycle later, Data=0x05060708.
REQ-040 Load 5 bytes AA BB CC DD EE, LdLast on EE -> mem[1]=0xEE000000, LdCount=2.
REQ-041 Load 68 bytes -> LdCount=16, LdErr=1, mem[15] holds bytes 61..64, Busy falls after LdLast.
REQ-042 En read during Busy -> Ack stays 0, Data unchanged; write during Busy -> target word unchanged.
REQ-043 Rst low after 2 bytes of a load -> Busy=0, LdCount=0, target word unchanged.
